// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among NUM_REQ requesters.
// Define SPI_ARB_FIXED_PRIO_EN for fixed (lowest-index-wins) priority instead of round-robin.
module spi_master_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned OWN_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_LENGTH-1:0]         rsp_data,
    output logic [OWN_W-1:0]               owner,
    output logic                           arb_busy,
    output logic                           m_start,
    output logic [DATA_LENGTH-1:0]         m_data_in,
    input  logic                           m_busy,
    input  logic                           m_done,
    input  logic [DATA_LENGTH-1:0]         m_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [DATA_LENGTH-1:0] tx_q, tx_d;
    logic [DATA_LENGTH-1:0] rx_q, rx_d;
    logic                   grant_vld_c;
    logic [OWN_W-1:0]       winner_c;

`ifdef SPI_ARB_FIXED_PRIO_EN
    // Lowest set index wins; scan downward so the last hit is the lowest.
    always_comb begin
        grant_vld_c = 1'b0;
        winner_c    = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_vld_c = 1'b1;
                winner_c    = OWN_W'(i);
            end
        end
    end
`else
    logic [OWN_W-1:0] ptr_q, ptr_d;

    // First valid request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned      sum;
        logic [OWN_W-1:0] idx;
        grant_vld_c = 1'b0;
        winner_c    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = OWN_W'(sum);
            if (!grant_vld_c && req_valid[idx]) begin
                grant_vld_c = 1'b1;
                winner_c    = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && grant_vld_c) begin
            ptr_d = (32'(winner_c) + 32'd1 >= NUM_REQ) ? '0 : winner_c + OWN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state and handshake decode; req_ready and m_start follow their inputs in-cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        req_ready = '0;
        m_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_c) begin
                    req_ready[winner_c] = 1'b1;
                    tx_d    = req_data[32'(winner_c)*DATA_LENGTH +: DATA_LENGTH];
                    owner_d = winner_c;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!m_busy) begin
                    m_start = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_done) begin
                    rx_d    = m_data_out;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign arb_busy  = (state_q != S_IDLE);
    assign owner     = owner_q;
    assign m_data_in = tx_q;
    assign rsp_data  = rx_q;

endmodule
